// File: rtl/pp_pkg.sv
// Shared definitions for the ping-pong counter and its run-control front end.
package pp_pkg;

  typedef enum logic {
    ST_PAUSE = 1'b0,
    ST_RUN   = 1'b1
  } pp_state_e;

  localparam int unsigned PP_DIV_DEF    = 4;
  localparam int unsigned PP_DB_LEN_DEF = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned pp_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pp_btn_pulse.sv
// Raw push-button to single-cycle press pulse: 2-flop synchroniser, debounce
// that needs DB_LEN consecutive differing samples, then rising-edge detect.
module pp_btn_pulse
  import pp_pkg::*;
#(
  parameter int unsigned DB_LEN = PP_DB_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);

  localparam int unsigned     CW       = pp_cnt_w(DB_LEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_LEN - 1);

  logic [1:0]    sync_q, sync_d;
  logic          level_q, level_d;
  logic          level_d1_q, level_d1_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Accept the synchronised level only after it has differed long enough.
  always_comb begin
    sync_d     = {sync_q[0], btn_raw};
    level_d    = level_q;
    level_d1_d = level_q;
    cnt_d      = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      level_q    <= 1'b0;
      level_d1_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync_q     <= sync_d;
      level_q    <= level_d;
      level_d1_q <= level_d1_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pulse = level_q & ~level_d1_q;

endmodule

// File: rtl/pp_enable_ctrl.sv
// Run-control for the ping-pong counter: periodic enable ticks in RUN,
// single-stepped ticks in PAUSE, toggled by a debounced pause button.
module pp_enable_ctrl
  import pp_pkg::*;
#(
  parameter int unsigned DIV           = PP_DIV_DEF,
  parameter int unsigned DB_LEN        = PP_DB_LEN_DEF,
  parameter bit          START_RUNNING = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_pause,
  input  logic btn_step,
  output logic enable,
  output logic running
);

  localparam int unsigned   PW       = pp_cnt_w(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam pp_state_e     ST_INIT  = START_RUNNING ? ST_RUN : ST_PAUSE;

  logic          pause_pulse;
  logic          step_pulse;
  pp_state_e     state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          enable_q, enable_d;

  pp_btn_pulse #(.DB_LEN(DB_LEN)) u_pause (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_pause),
    .pulse   (pause_pulse)
  );

  pp_btn_pulse #(.DB_LEN(DB_LEN)) u_step (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_step),
    .pulse   (step_pulse)
  );

  // Pause pulse wins over both a due tick and a step; prescaler restarts on
  // every state change so the first RUN tick lands DIV cycles after entry.
  always_comb begin
    state_d  = state_q;
    presc_d  = '0;
    enable_d = 1'b0;
    case (state_q)
      ST_PAUSE: begin
        enable_d = step_pulse & ~pause_pulse;
        if (pause_pulse) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        enable_d = (presc_q == PRE_LAST) & ~pause_pulse;
        if (pause_pulse) begin
          state_d = ST_PAUSE;
        end else if (presc_q != PRE_LAST) begin
          presc_d = presc_q + PW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      presc_q  <= '0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      enable_q <= enable_d;
    end
  end

  assign enable  = enable_q;
  assign running = (state_q == ST_RUN);

endmodule

// File: doc/pp_enable_ctrl.md
Name: pp_enable_ctrl

Overview:
Upstream run-control stage for the ping-pong counter. It produces the counter's `enable` input: one-cycle pulses that are either periodic (RUN) or single-stepped (PAUSE). It takes two raw, unsynchronised push-buttons: pause/resume toggle and single-step. The `enable` output connects directly to the counter's enable; the counter advances exactly once per pulse.

Parameters:
DIV, 4, RUN-mode tick period in clk cycles (DIV >= 1)
DB_LEN, 4, consecutive stable synchronised samples required to accept a button level change (DB_LEN >= 1)
START_RUNNING, 0, FSM state on reset release (0 = PAUSE, 1 = RUN)

Ports:
clk  input  1  system clock; all state updates on posedge
rst_n  input  1  asynchronous, active-low reset
btn_pause  input  1  raw pause/resume button, active-high, asynchronous to clk
btn_step  input  1  raw single-step button, active-high, asynchronous to clk
enable  output  1  registered one-cycle advance pulse to the ping-pong counter
running  output  1  registered; 1 = RUN state, 0 = PAUSE state

Behaviour:
- Reset (rst_n=0, async, takes effect immediately, including mid-operation):
  - enable=0; running=START_RUNNING; prescaler=0.
  - Synchroniser flops, debounced levels, previous-level flops and debounce counters all 0.
- Per-button front end (identical for both buttons):
  - 2-flop synchroniser.
  - Debounce: if sync != level, cnt++; when cnt == DB_LEN-1 and still differing, level <= sync and cnt <= 0. If sync == level, cnt <= 0.
  - Pulse = level & ~level_d1. It is high for exactly one cycle per accepted press. Release produces no pulse.
- Button latency: raw input rises before edge 1 and stays high.
  - Synchronised value high after edge 2.
  - Debounced level high after edge 2+DB_LEN.
  - Pulse high in the cycle after edge 2+DB_LEN.
  - Its effect (state or enable) is registered at edge 3+DB_LEN.
- Glitch rejection: a raw glitch shorter than DB_LEN synchronised cycles never changes level and never pulses.
- FSM states PAUSE and RUN:
  - PAUSE --pause_pulse--> RUN
  - RUN --pause_pulse--> PAUSE
  - Otherwise the state holds.
  - running mirrors the state register.
- Prescaler, width max(1, clog2(DIV)):
  - In RUN: counts 0..DIV-1 and wraps to 0.
  - In PAUSE: held at 0.
  - Forced to 0 on any state transition, so the first RUN tick occurs DIV cycles after entering RUN.
- Next-enable (registered at the next edge):
  - RUN: enable_next = (prescaler == DIV-1) & ~pause_pulse.
  - PAUSE: enable_next = step_pulse & ~pause_pulse.
- DIV=1: enable is high every cycle while in RUN.
- Simultaneous pause_pulse and step_pulse: pause wins; step is discarded and is not queued.
- step_pulse in RUN: ignored, with no extra pulse.
- Holding btn_step: one pulse only; a new press requires a release to be accepted first.
- enable never stays high for two consecutive cycles unless DIV=1 in RUN.

Decomposition:
- Shared package pp_pkg:
  - State encoding constants ST_PAUSE=1'b0, ST_RUN=1'b1.
  - Default DIV and DB_LEN constants, also reused by the ping-pong counter's top-level integration.
- One natural sub-module, pp_btn_pulse (parameter DB_LEN; ports clk, rst_n, btn_raw, pulse): synchroniser + debounce + one-pulse.
  - pp_enable_ctrl instantiates it twice and holds the FSM, prescaler and enable register.

Test Plan:
1. Reset with START_RUNNING=0, DIV=4 -> enable=0 and running=0 throughout; enable stays 0 after release for 20 idle cycles.
2. DB_LEN=4: raise btn_pause before edge 1 and hold -> running=1 after edge 7. First enable pulse after edge 11, then every 4 cycles (edges 15, 19, ...), each exactly 1 cycle wide.
3. In PAUSE: a 2-cycle btn_step glitch -> no enable. A held btn_step -> exactly one enable pulse, 7 edges after the press. Release and press again -> a second pulse.
4. In RUN, press btn_pause timed so pause_pulse coincides with prescaler==3 -> that tick is suppressed; running=0; no further enable pulses.
5. btn_pause and btn_step pressed in the same cycle while in PAUSE -> running becomes 1; no step pulse appears on enable; next enable comes DIV cycles later.
6. Deassert rst_n asynchronously mid-RUN with prescaler=2 -> enable=0 and running=START_RUNNING immediately, without waiting for a clk edge. After release, with btn_pause still held from before reset, one new pulse is generated once the debounce is satisfied.
